// File: rtl/spart_bus_ctrl_if.sv
// Processor-side bus of the SPART bus controller: chip select, direction,
// register address and the split read/write data paths.
interface spart_bus_ctrl_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] databus_in;
   logic [7:0] databus_out;
   logic       databus_oe;

   modport master (
      output iocs, iorw, ioaddr, databus_in,
      input  databus_out, databus_oe
   );

   modport slave (
      input  iocs, iorw, ioaddr, databus_in,
      output databus_out, databus_oe
   );
endinterface

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: register decode, transmit hand-off FSM, receive
// buffer and baud divisor register.
// Optional macro SPART_ERRFLAG_EN builds the tx_ovf / rx_ovr sticky flags;
// without it, status bits 3:2 read as zero.
module spart_bus_ctrl #(
   parameter logic [15:0] DIV_RESET = 16'h0145
) (
   input  logic             clk,
   input  logic             rst,
   spart_bus_ctrl_if.slave  bus,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   input  logic             tx_busy,
   input  logic [7:0]       rx_data,
   input  logic             rx_done,
   output logic [15:0]      divisor,
   output logic             div_load,
   output logic             tbr,
   output logic             rda
);

   typedef enum logic [1:0] {
      TX_EMPTY  = 2'b00,
      TX_FULL   = 2'b01,
      TX_LAUNCH = 2'b10
   } tx_state_e;

   tx_state_e   tx_state_q, tx_state_d;
   logic [7:0]  thr_q, thr_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  rbr_q, rbr_d;
   logic        rda_q, rda_d;
   logic [15:0] divisor_q, divisor_d;
   logic        div_load_q, div_load_d;
   logic        first_q, first_d;
   logic        wr_s, rd_s, wr_data_s, rd_data_s, wr_divlo_s, wr_divhi_s;
   logic        tx_ovf_s, rx_ovr_s;

   // Access decode: one strobe per register/direction.
   always_comb begin
      wr_s       = bus.iocs & ~bus.iorw;
      rd_s       = bus.iocs & bus.iorw;
      wr_data_s  = wr_s & (bus.ioaddr == 2'b00);
      rd_data_s  = rd_s & (bus.ioaddr == 2'b00);
      wr_divlo_s = wr_s & (bus.ioaddr == 2'b10);
      wr_divhi_s = wr_s & (bus.ioaddr == 2'b11);
   end

   // TX FSM state register plus the registered transmit outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_EMPTY;
         thr_q      <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         thr_q      <= thr_d;
         tx_start_q <= tx_start_d;
      end
   end

   // TX FSM next state: accept a byte, wait for an idle transmitter, wait for it to pick up.
   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_EMPTY: begin
            if (wr_data_s) tx_state_d = TX_FULL;
            else           tx_state_d = TX_EMPTY;
         end
         TX_FULL: begin
            if (!tx_busy) tx_state_d = TX_LAUNCH;
            else          tx_state_d = TX_FULL;
         end
         TX_LAUNCH: begin
            if (tx_busy) tx_state_d = TX_EMPTY;
            else         tx_state_d = TX_LAUNCH;
         end
         default: tx_state_d = TX_EMPTY;
      endcase
   end

   // TX FSM outputs: holding register load and the one-cycle launch pulse.
   always_comb begin
      thr_d      = thr_q;
      tx_start_d = 1'b0;
      case (tx_state_q)
         TX_EMPTY: begin
            if (wr_data_s) thr_d = bus.databus_in;
            else           thr_d = thr_q;
         end
         TX_FULL: begin
            if (!tx_busy) tx_start_d = 1'b1;
            else          tx_start_d = 1'b0;
         end
         TX_LAUNCH: tx_start_d = 1'b0;
         default:   tx_start_d = 1'b0;
      endcase
   end

   // Receive buffer, divisor register and reload pulse next-state logic.
   always_comb begin
      rbr_d = rbr_q;
      rda_d = rda_q;
      if (rx_done) begin
         rbr_d = rx_data;
         rda_d = 1'b1;
      end else if (rd_data_s) begin
         rda_d = 1'b0;
      end else begin
         rda_d = rda_q;
      end
      divisor_d = divisor_q;
      if (wr_divlo_s)      divisor_d = {divisor_q[15:8], bus.databus_in};
      else if (wr_divhi_s) divisor_d = {bus.databus_in, divisor_q[7:0]};
      else                 divisor_d = divisor_q;
      // first_q makes the generator load DIV_RESET once after reset
      div_load_d = wr_divhi_s | first_q;
      first_d    = 1'b0;
   end

   // Receive, divisor and reload flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         rbr_q      <= 8'h00;
         rda_q      <= 1'b0;
         divisor_q  <= DIV_RESET;
         div_load_q <= 1'b0;
         first_q    <= 1'b1;
      end else begin
         rbr_q      <= rbr_d;
         rda_q      <= rda_d;
         divisor_q  <= divisor_d;
         div_load_q <= div_load_d;
         first_q    <= first_d;
      end
   end

`ifdef SPART_ERRFLAG_EN
   logic tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, rd_stat_s;

   // Sticky error flags: a set event in the same cycle wins over the status-read clear.
   always_comb begin
      rd_stat_s = rd_s & (bus.ioaddr == 2'b01);
      if (wr_data_s && (tx_state_q != TX_EMPTY)) tx_ovf_d = 1'b1;
      else if (rd_stat_s)                       tx_ovf_d = 1'b0;
      else                                      tx_ovf_d = tx_ovf_q;
      if (rx_done && rda_q && !rd_data_s)       rx_ovr_d = 1'b1;
      else if (rd_stat_s)                       rx_ovr_d = 1'b0;
      else                                      rx_ovr_d = rx_ovr_q;
   end

   // Error flag flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ovf_q <= 1'b0;
         rx_ovr_q <= 1'b0;
      end else begin
         tx_ovf_q <= tx_ovf_d;
         rx_ovr_q <= rx_ovr_d;
      end
   end

   assign tx_ovf_s = tx_ovf_q;
   assign rx_ovr_s = rx_ovr_q;
`else
   assign tx_ovf_s = 1'b0;
   assign rx_ovr_s = 1'b0;
`endif

   // Zero-latency read mux; read side effects land on the closing edge.
   always_comb begin
      case (bus.ioaddr)
         2'b00:   bus.databus_out = rbr_q;
         2'b01:   bus.databus_out = {4'b0000, rx_ovr_s, tx_ovf_s, rda_q, tbr};
         2'b10:   bus.databus_out = divisor_q[7:0];
         2'b11:   bus.databus_out = divisor_q[15:8];
         default: bus.databus_out = 8'h00;
      endcase
   end

   assign bus.databus_oe = bus.iocs & bus.iorw;
   assign tbr            = (tx_state_q == TX_EMPTY);
   assign rda            = rda_q;
   assign tx_data        = thr_q;
   assign tx_start       = tx_start_q;
   assign divisor        = divisor_q;
   assign div_load       = div_load_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Self-checking bench for spart_bus_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_spart_bus_ctrl;

`ifdef SPART_ERRFLAG_EN
   localparam bit ERRF = 1'b1;
`else
   localparam bit ERRF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic [15:0] divisor;
   logic        div_load;
   logic        tbr;
   logic        rda;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   spart_bus_ctrl_if bus_if();

   spart_bus_ctrl #(.DIV_RESET(16'h0145)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .divisor  (divisor),
      .div_load (div_load),
      .tbr      (tbr),
      .rda      (rda)
   );

   always #5 clk = ~clk;

   // Behavioural model: a byte is "waiting" until the transmitter is idle,
   // then "handed over" until the transmitter reports busy.
   logic [7:0]  m_thr, m_rbr;
   logic        m_waiting, m_handed, m_start, m_rda, m_txovf, m_rxovr;
   logic [15:0] m_div;
   logic        m_divload, m_first;

   function automatic logic m_tbr();
      return !(m_waiting || m_handed);
   endfunction

   function automatic logic [7:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return m_rbr;
         2'd1:    return {4'b0000, m_rxovr, m_txovf, m_rda, m_tbr()};
         2'd2:    return m_div[7:0];
         default: return m_div[15:8];
      endcase
   endfunction

   task automatic model_step();
      logic wr0, wr2, wr3, rd0, rd1, old_tbr, old_rda;
      if (rst) begin
         m_thr = 8'h00; m_rbr = 8'h00; m_waiting = 1'b0; m_handed = 1'b0;
         m_start = 1'b0; m_rda = 1'b0; m_txovf = 1'b0; m_rxovr = 1'b0;
         m_div = 16'h0145; m_divload = 1'b0; m_first = 1'b1;
      end else begin
         wr0 = bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'd0;
         wr2 = bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'd2;
         wr3 = bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'd3;
         rd0 = bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'd0;
         rd1 = bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'd1;
         old_tbr = m_tbr();
         old_rda = m_rda;
         m_start = m_waiting && !tx_busy;
         if (m_waiting) begin
            if (!tx_busy) begin m_waiting = 1'b0; m_handed = 1'b1; end
         end else if (m_handed) begin
            if (tx_busy) m_handed = 1'b0;
         end else if (wr0) begin
            m_thr = bus_if.databus_in; m_waiting = 1'b1;
         end
         if (ERRF) begin
            if (wr0 && !old_tbr) m_txovf = 1'b1;
            else if (rd1)        m_txovf = 1'b0;
            if (rx_done && old_rda && !rd0) m_rxovr = 1'b1;
            else if (rd1)                   m_rxovr = 1'b0;
         end
         if (rx_done) begin m_rbr = rx_data; m_rda = 1'b1; end
         else if (rd0) m_rda = 1'b0;
         if (wr2) m_div[7:0]  = bus_if.databus_in;
         if (wr3) m_div[15:8] = bus_if.databus_in;
         m_divload = wr3 || m_first;
         m_first   = 1'b0;
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("m_tbr",      {15'd0, tbr},      {15'd0, m_tbr()});
         chk("m_rda",      {15'd0, rda},      {15'd0, m_rda});
         chk("m_tx_start", {15'd0, tx_start}, {15'd0, m_start});
         chk("m_tx_data",  {8'd0, tx_data},   {8'd0, m_thr});
         chk("m_divisor",  divisor,           m_div);
         chk("m_div_load", {15'd0, div_load}, {15'd0, m_divload});
         chk("m_oe", {15'd0, bus_if.databus_oe}, {15'd0, bus_if.iocs & bus_if.iorw});
         if (bus_if.iocs && bus_if.iorw)
            chk("m_rdata", {8'd0, bus_if.databus_out}, {8'd0, m_read(bus_if.ioaddr)});
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic bus_idle();
      bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'd0; bus_if.databus_in = 8'h00;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = a; bus_if.databus_in = d;
      cycle();
      bus_idle();
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = a; bus_if.databus_in = 8'h00;
      #1;
      d = bus_if.databus_out;
      cycle();
      bus_idle();
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      rx_done = 1'b1; rx_data = d;
      cycle();
      rx_done = 1'b0;
   endtask

   logic [7:0] rd_v;

   initial begin
      rst = 1'b1; tx_busy = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
      bus_idle();
      cycle();
      cycle();
      check_en = 1'b1;
      rst = 1'b0;
      // Reset state and the single post-reset reload pulse
      chk("rst_tbr", {15'd0, tbr}, 16'd1);
      chk("rst_rda", {15'd0, rda}, 16'd0);
      chk("rst_div", divisor, 16'h0145);
      chk("rst_dl_before", {15'd0, div_load}, 16'd0);
      cycle();
      chk("rst_dl_pulse", {15'd0, div_load}, 16'd1);
      cycle();
      chk("rst_dl_once", {15'd0, div_load}, 16'd0);

      // Divisor programming
      bus_wr(2'd2, 8'h8A);
      chk("divlo_no_load", {15'd0, div_load}, 16'd0);
      bus_wr(2'd3, 8'h02);
      chk("divhi_load", {15'd0, div_load}, 16'd1);
      chk("div_value", divisor, 16'h028A);
      cycle();
      chk("divhi_load_end", {15'd0, div_load}, 16'd0);
      bus_rd(2'd2, rd_v);
      chk("rd_divlo", {8'd0, rd_v}, 16'h008A);
      bus_rd(2'd3, rd_v);
      chk("rd_divhi", {8'd0, rd_v}, 16'h0002);
      bus_wr(2'd3, 8'h03);
      bus_wr(2'd3, 8'h04);
      chk("b2b_divhi_load", {15'd0, div_load}, 16'd1);
      bus_wr(2'd3, 8'h02);

      // Transmit launch handshake
      bus_wr(2'd0, 8'h55);
      chk("tx_tbr_low", {15'd0, tbr}, 16'd0);
      chk("tx_start_pre", {15'd0, tx_start}, 16'd0);
      cycle();
      chk("tx_start", {15'd0, tx_start}, 16'd1);
      chk("tx_data", {8'd0, tx_data}, 16'h0055);
      cycle();
      chk("tx_start_once", {15'd0, tx_start}, 16'd0);
      cycle();
      chk("tx_launch_hold", {15'd0, tbr}, 16'd0);
      tx_busy = 1'b1;
      cycle();
      chk("tx_tbr_back", {15'd0, tbr}, 16'd1);

      // Overflow while transmitter busy
      bus_wr(2'd0, 8'hA1);
      bus_wr(2'd0, 8'hB2);
      chk("ovf_tx_data", {8'd0, tx_data}, 16'h00A1);
      bus_rd(2'd1, rd_v);
      chk("ovf_status", {8'd0, rd_v}, ERRF ? 16'h0004 : 16'h0000);
      bus_rd(2'd1, rd_v);
      chk("ovf_cleared", {8'd0, rd_v}, 16'h0000);
      tx_busy = 1'b0;
      cycle();
      tx_busy = 1'b1;
      cycle();
      tx_busy = 1'b0;
      cycle();

      // Receive overrun
      rx_pulse(8'h3C);
      rx_pulse(8'h7E);
      chk("rx_rda", {15'd0, rda}, 16'd1);
      bus_rd(2'd1, rd_v);
      chk("rx_ovr_status", {8'd0, rd_v}, ERRF ? 16'h000B : 16'h0003);
      bus_rd(2'd0, rd_v);
      chk("rx_rd_data", {8'd0, rd_v}, 16'h007E);
      chk("rx_rda_clr", {15'd0, rda}, 16'd0);

      // Read colliding with a new byte
      rx_pulse(8'h22);
      bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = 2'd0;
      rx_done = 1'b1; rx_data = 8'h11;
      #1;
      chk("coll_old_byte", {8'd0, bus_if.databus_out}, 16'h0022);
      cycle();
      rx_done = 1'b0;
      bus_idle();
      chk("coll_rda_kept", {15'd0, rda}, 16'd1);
      bus_rd(2'd0, rd_v);
      chk("coll_new_byte", {8'd0, rd_v}, 16'h0011);

      // Reset in the middle of a launch
      bus_wr(2'd0, 8'h99);
      cycle();
      chk("abort_start_pre", {15'd0, tx_start}, 16'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("abort_start", {15'd0, tx_start}, 16'd0);
      chk("abort_tbr", {15'd0, tbr}, 16'd1);
      chk("abort_thr", {8'd0, tx_data}, 16'h0000);
      chk("abort_div", divisor, 16'h0145);
      cycle();
      cycle();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 399) == 0);
         bus_if.iocs = $urandom_range(0, 1) == 1;
         bus_if.iorw = $urandom_range(0, 1) == 1;
         bus_if.ioaddr = 2'($urandom_range(0, 3));
         bus_if.databus_in = 8'($urandom);
         tx_busy = $urandom_range(0, 2) == 0;
         rx_done = $urandom_range(0, 5) == 0;
         rx_data = 8'($urandom);
         cycle();
      end
      rst = 1'b0; rx_done = 1'b0; tx_busy = 1'b0;
      bus_idle();
      cycle();
      cycle();
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
